// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives the combinational ROM address, and loads the
// returned word plus PC metadata into the IF/ID register.
module fetch_stage #(
  parameter int unsigned            DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0]  FIRST_INSTR_ADDR = 32'hBFC00000,
  parameter logic [DATA_WIDTH-1:0]  LAST_INSTR_ADDR  = 32'hBFC00FFF,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR        = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f_i,
  input  logic                  stall_d_i,
  input  logic                  flush_d_i,
  input  logic                  pc_src_e_i,
  input  logic [DATA_WIDTH-1:0] pc_target_e_i,
  input  logic [DATA_WIDTH-1:0] instr_f_i,
  output logic [DATA_WIDTH-1:0] pc_f_o,
  output logic [DATA_WIDTH-1:0] instr_d_o,
  output logic [DATA_WIDTH-1:0] pc_d_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_d_o,
  output logic                  valid_d_o,
  output logic                  fault_d_o,
  output logic [31:0]           fetch_count_o
);

  localparam int unsigned CNT_W = 32;
  // Highest address at which a full word still lies inside the ROM.
  localparam logic [DATA_WIDTH-1:0] LAST_WORD_ADDR = LAST_INSTR_ADDR - DATA_WIDTH'(3);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  valid;
    logic                  fault;
  } ifid_t;

  localparam ifid_t BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0,
    fault:    1'b0
  };

  logic [DATA_WIDTH-1:0] pc_q, pc_n, pc_plus4;
  ifid_t                 ifid_q, ifid_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic                  out_of_range;
  logic                  unused_target_lsbs;

  // Redirect targets are forced to word alignment, so the two LSBs are dropped.
  assign unused_target_lsbs = ^pc_target_e_i[1:0];

  assign pc_plus4     = pc_q + DATA_WIDTH'(4);
  assign out_of_range = (pc_q < FIRST_INSTR_ADDR) || (pc_q > LAST_WORD_ADDR);

  // Next-state for PC, IF/ID register and fetch counter.
  always_comb begin
    pc_n   = pc_q;
    ifid_n = ifid_q;
    cnt_n  = cnt_q;

    if (pc_src_e_i) begin
      pc_n = {pc_target_e_i[DATA_WIDTH-1:2], 2'b00};
    end else if (!stall_f_i) begin
      pc_n = pc_plus4;
    end

    if (flush_d_i || pc_src_e_i) begin
      ifid_n = BUBBLE;
    end else if (!stall_d_i) begin
      ifid_n.instr    = out_of_range ? NOP_INSTR : instr_f_i;
      ifid_n.pc       = pc_q;
      ifid_n.pc_plus4 = pc_plus4;
      ifid_n.valid    = 1'b1;
      ifid_n.fault    = out_of_range;
      cnt_n           = cnt_q + CNT_W'(1);
    end
  end

  // State registers with immediate reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= FIRST_INSTR_ADDR;
      ifid_q <= BUBBLE;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_n;
      ifid_q <= ifid_n;
      cnt_q  <= cnt_n;
    end
  end

  assign pc_f_o        = pc_q;
  assign instr_d_o     = ifid_q.instr;
  assign pc_d_o        = ifid_q.pc;
  assign pc_plus4_d_o  = ifid_q.pc_plus4;
  assign valid_d_o     = ifid_q.valid;
  assign fault_d_o     = ifid_q.fault;
  assign fetch_count_o = cnt_q;

endmodule
